// File: rtl/hilo_muldiv_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit.
//  - ALU control codes for the four HI/LO-producing operations (shared with aludec)
//  - FSM state type for the unit controller
//  - Helper predicates and the divide latency formula
package hilo_muldiv_unit_pkg;

  // ALU control codes, kept bit-identical to the decoder's definitions.
  localparam logic [7:0] EXE_AND_OP   = 8'b0010_0100;
  localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
  localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMul  = 2'd1,
    StDiv  = 2'd2,
    StDone = 2'd3
  } mdu_state_e;

  function automatic logic is_muldiv_op(input logic [7:0] op);
    return (op == EXE_MULT_OP) || (op == EXE_MULTU_OP) ||
           (op == EXE_DIV_OP)  || (op == EXE_DIVU_OP);
  endfunction

  function automatic logic is_mul_op(input logic [7:0] op);
    return (op == EXE_MULT_OP) || (op == EXE_MULTU_OP);
  endfunction

  function automatic logic is_signed_op(input logic [7:0] op);
    return (op == EXE_MULT_OP) || (op == EXE_DIV_OP);
  endfunction

  // Accept edge to done cycle for a divide: one restoring iteration per bit plus a sign-fix.
  function automatic int unsigned div_latency(input int unsigned data_w);
    return data_w + 1;
  endfunction

endpackage

// File: rtl/hilo_muldiv_unit_div_core.sv
// Iterative restoring divider on unsigned magnitudes.
//  The first iteration is performed on the start edge straight from the operands, so
//  DATA_W iterations complete DATA_W-1 edges after start and done pulses in the
//  following cycle with quotient/remainder stable.
// Ports:
//  clk, rst   clock, asynchronous active-high reset
//  abort      drop the in-flight division, no done
//  start      begin a division with dividend/divisor
//  dividend   unsigned dividend magnitude
//  divisor    unsigned divisor magnitude (zero gives all-ones quotient, remainder=dividend)
//  done       one-cycle pulse, quotient/remainder valid
//  quotient   result quotient
//  remainder  result remainder
module hilo_muldiv_unit_div_core #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              abort,
  input  logic              start,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);

  localparam int unsigned CntW = $clog2(DATA_W);

  logic [DATA_W-1:0] rem_q, quot_q, dvsr_q;
  logic [CntW-1:0]   cnt_q;
  logic              run_q, done_q;

  logic [DATA_W-1:0] rem_in, quot_in, dvsr_in;
  logic [DATA_W:0]   shifted, diff;
  logic [DATA_W-1:0] rem_nxt, quot_nxt;

  // One restoring step; on start the step consumes the fresh operands directly.
  always_comb begin
    rem_in   = start ? '0 : rem_q;
    quot_in  = start ? dividend : quot_q;
    dvsr_in  = start ? divisor : dvsr_q;
    shifted  = {rem_in, quot_in[DATA_W-1]};
    diff     = shifted - {1'b0, dvsr_in};
    rem_nxt  = shifted[DATA_W-1:0];
    quot_nxt = {quot_in[DATA_W-2:0], 1'b0};
    if (!diff[DATA_W]) begin
      rem_nxt  = diff[DATA_W-1:0];
      quot_nxt = {quot_in[DATA_W-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q  <= '0;
      quot_q <= '0;
      dvsr_q <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort) begin
        run_q <= 1'b0;
      end else if (start) begin
        rem_q  <= rem_nxt;
        quot_q <= quot_nxt;
        dvsr_q <= divisor;
        cnt_q  <= CntW'(DATA_W - 1);
        run_q  <= 1'b1;
      end else if (run_q) begin
        rem_q  <= rem_nxt;
        quot_q <= quot_nxt;
        cnt_q  <= cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          run_q  <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done      = done_q;
  assign quotient  = quot_q;
  assign remainder = rem_q;

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Multi-cycle multiply/divide unit for the EX stage producing the {HI,LO} pair for
// MULT/MULTU/DIV/DIVU. Stalls the pipeline while busy and pulses done with the result.
// Ports:
//  clk, rst   clock, asynchronous active-high reset
//  flush_i    abort the in-flight op; beats a simultaneous start or completion
//  start_i    request from EX; accepted in IDLE or DONE for a supported op_i
//  op_i       ALU control code
//  a_i, b_i   rs / rt operands
//  stall_o    accepting or MUL/DIV in flight
//  busy_o     MUL/DIV in flight
//  done_o     one-cycle pulse, hi_o/lo_o valid
//  hi_o, lo_o MUL: upper/lower product; DIV: remainder/quotient
module hilo_muldiv_unit
  import hilo_muldiv_unit_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MUL_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              start_i,
  input  logic [7:0]        op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              stall_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  localparam int unsigned MulCntW = (MUL_STAGES > 1) ? $clog2(MUL_STAGES) : 1;
  localparam int unsigned MulLast = (MUL_STAGES > 1) ? MUL_STAGES - 2 : 0;

  mdu_state_e state_q, state_d;
  logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [MulCntW-1:0] mul_cnt_q;

  logic busy, accept, op_signed, op_mul;

  assign op_mul    = is_mul_op(op_i);
  assign op_signed = is_signed_op(op_i);
  assign busy      = (state_q == StMul) || (state_q == StDiv);
  assign accept    = start_i && is_muldiv_op(op_i) && !busy && !flush_i;

  // ---------------------------------------------------------------- multiply path
  logic [2*DATA_W-1:0] a_ext, b_ext, mul_prod, mul_res;

  always_comb begin
    a_ext    = {{DATA_W{op_signed & a_i[DATA_W-1]}}, a_i};
    b_ext    = {{DATA_W{op_signed & b_i[DATA_W-1]}}, b_i};
    mul_prod = a_ext * b_ext;
  end

  if (MUL_STAGES == 1) begin : g_mul_comb
    assign mul_res = mul_prod;
  end else begin : g_mul_pipe
    logic [2*DATA_W-1:0] pipe_q [MUL_STAGES-1];
    // Stage 0 is the product register; the rest is a plain delay line for retiming.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int unsigned i = 0; i < MUL_STAGES - 1; i++) pipe_q[i] <= '0;
      end else begin
        if (accept && op_mul) pipe_q[0] <= mul_prod;
        for (int unsigned i = 1; i < MUL_STAGES - 1; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end
    assign mul_res = pipe_q[MUL_STAGES-2];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_cnt_q <= '0;
    end else if (accept) begin
      mul_cnt_q <= '0;
    end else if (state_q == StMul) begin
      mul_cnt_q <= mul_cnt_q + MulCntW'(1);
    end
  end

  // ---------------------------------------------------------------- divide path
  logic              a_neg, b_neg;
  logic [DATA_W-1:0] a_mag, b_mag;
  logic              q_neg_q, r_neg_q, div0_q;
  logic [DATA_W-1:0] dividend_q;
  logic              div_done;
  logic [DATA_W-1:0] div_quot, div_rem, q_fix, r_fix;

  always_comb begin
    a_neg = op_signed & a_i[DATA_W-1];
    b_neg = op_signed & b_i[DATA_W-1];
    a_mag = a_neg ? -a_i : a_i;
    b_mag = b_neg ? -b_i : b_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      div0_q     <= 1'b0;
      dividend_q <= '0;
    end else if (accept && !op_mul) begin
      q_neg_q    <= a_neg ^ b_neg;
      r_neg_q    <= a_neg;
      div0_q     <= (b_i == '0);
      dividend_q <= a_i;
    end
  end

  hilo_muldiv_unit_div_core #(
    .DATA_W (DATA_W)
  ) u_div_core (
    .clk       (clk),
    .rst       (rst),
    .abort     (flush_i),
    .start     (accept && !op_mul),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .done      (div_done),
    .quotient  (div_quot),
    .remainder (div_rem)
  );

  // Sign-fix; divide-by-zero bypasses it so signed and unsigned report the raw dividend.
  // MIN / -1 falls out naturally: magnitude quotient 2^(W-1) with positive sign wraps to MIN.
  always_comb begin
    q_fix = q_neg_q ? -div_quot : div_quot;
    r_fix = r_neg_q ? -div_rem : div_rem;
    if (div0_q) begin
      q_fix = '1;
      r_fix = dividend_q;
    end
  end

  // ---------------------------------------------------------------- control FSM
  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (accept) begin
          if (!op_mul) begin
            state_d = StDiv;
          end else if (MUL_STAGES == 1) begin
            state_d = StDone;
            {hi_d, lo_d} = mul_res;
          end else begin
            state_d = StMul;
          end
        end else if (state_q == StDone) begin
          state_d = StIdle;
        end
      end
      StMul: begin
        if (mul_cnt_q == MulCntW'(MulLast)) begin
          state_d = StDone;
          {hi_d, lo_d} = mul_res;
        end
      end
      StDiv: begin
        if (div_done) begin
          state_d = StDone;
          hi_d    = r_fix;
          lo_d    = q_fix;
        end
      end
    endcase
    if (flush_i) begin
      state_d = StIdle;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy_o  = busy;
  assign stall_o = accept || busy;
  assign done_o  = (state_q == StDone);
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit (DATA_W=32, MUL_STAGES=2): directed corner
// cases followed by randomized operations against a plain-arithmetic reference model.
module tb_hilo_muldiv_unit;
  import hilo_muldiv_unit_pkg::*;

  localparam int unsigned W = 32;
  localparam int MulLat = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush_i = 1'b0;
  logic          start_i = 1'b0;
  logic [7:0]    op_i = '0;
  logic [W-1:0]  a_i = '0;
  logic [W-1:0]  b_i = '0;
  logic          stall_o, busy_o, done_o;
  logic [W-1:0]  hi_o, lo_o;

  int n_vec = 0;
  int n_err = 0;
  logic [63:0] last_hilo = '0;

  hilo_muldiv_unit #(
    .DATA_W     (W),
    .MUL_STAGES (2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush_i),
    .start_i (start_i),
    .op_i    (op_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .stall_o (stall_o),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .hi_o    (hi_o),
    .lo_o    (lo_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got hang, want finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  // Returns {hi, lo} computed straight from the arithmetic definition.
  function automatic logic [63:0] ref_model(input logic [7:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'({{32{a[31]}}, a});
    sb = longint'({{32{b[31]}}, b});
    p  = '0;
    if (op == EXE_MULT_OP) begin
      p = 64'(sa * sb);
    end else if (op == EXE_MULTU_OP) begin
      p = {32'h0, a} * {32'h0, b};
    end else if (b == 32'h0) begin
      p = {a, 32'hFFFF_FFFF};
    end else if (op == EXE_DIVU_OP) begin
      p = {a % b, a / b};
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      p = {32'h0, 32'h8000_0000};
    end else begin
      q = sa / sb;
      r = sa % sb;
      p = {r[31:0], q[31:0]};
    end
    return p;
  endfunction

  // Called at negedge+1; issues the op and returns at negedge+1 of the done cycle.
  // poke re-asserts start in cycle 1 to show a busy unit ignores it.
  task automatic run_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input logic poke);
    logic [63:0] exp;
    int          cyc;
    exp = ref_model(op, a, b);
    start_i = 1'b1;
    op_i    = op;
    a_i     = a;
    b_i     = b;
    #1 check_eq("stall_on_accept", 64'(stall_o), 64'(1));
    @(negedge clk);
    start_i = poke;
    op_i    = EXE_MULTU_OP;
    a_i     = $urandom;
    b_i     = $urandom;
    #1;
    cyc = 1;
    while (done_o !== 1'b1 && cyc < 60) begin
      check_eq("stall_busy_inflight", 64'({stall_o, busy_o}), 64'(2'b11));
      @(negedge clk);
      start_i = 1'b0;
      #1;
      cyc++;
    end
    start_i = 1'b0;
    check_eq("done_cycle", 64'(cyc), 64'(lat));
    check_eq("hi", 64'(hi_o), 64'(exp[63:32]));
    check_eq("lo", 64'(lo_o), 64'(exp[31:0]));
    check_eq("stall_busy_done", 64'({stall_o, busy_o}), 64'(0));
    last_hilo = exp;
  endtask

  task automatic step_idle();
    @(negedge clk);
    #1 check_eq("done_pulse_one_cycle", 64'(done_o), 64'(0));
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(1, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    logic [7:0] ops [4];
    int         seen_done;
    int         div_lat;
    ops[0] = EXE_MULT_OP;
    ops[1] = EXE_MULTU_OP;
    ops[2] = EXE_DIV_OP;
    ops[3] = EXE_DIVU_OP;
    div_lat = int'(div_latency(W));

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_outputs", 64'({stall_o, busy_o, done_o}), 64'(0));
    check_eq("rst_hilo", {hi_o, lo_o}, 64'(0));
    rst = 1'b0;
    @(negedge clk);
    #1;

    // MULT / MULTU, then a back-to-back DIV accepted in the DONE cycle
    run_op(EXE_MULT_OP, 32'hFFFF_FFFE, 32'h3, MulLat, 1'b0);
    step_idle();
    run_op(EXE_MULTU_OP, 32'hFFFF_FFFE, 32'h3, MulLat, 1'b0);
    run_op(EXE_DIV_OP, 32'hFFFF_FFF9, 32'h2, div_lat, 1'b1);
    step_idle();
    run_op(EXE_DIVU_OP, 32'hFFFF_FFF9, 32'h2, div_lat, 1'b0);
    step_idle();
    run_op(EXE_DIVU_OP, 32'h1234_5678, 32'h0, div_lat, 1'b0);
    step_idle();
    run_op(EXE_DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF, div_lat, 1'b0);
    step_idle();

    // Flush a DIV in cycle 10
    start_i = 1'b1; op_i = EXE_DIV_OP; a_i = 32'd1000; b_i = 32'd7;
    @(negedge clk);
    start_i = 1'b0;
    repeat (9) @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    #1;
    check_eq("flush_busy", 64'({busy_o, done_o}), 64'(0));
    check_eq("flush_hilo_kept", {hi_o, lo_o}, last_hilo);
    seen_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_o === 1'b1) seen_done++;
    end
    check_eq("flush_no_done", 64'(seen_done), 64'(0));
    #1;
    run_op(EXE_MULTU_OP, 32'd5, 32'd7, MulLat, 1'b0);

    // Flush in the DONE cycle: done stays up, simultaneous start loses
    flush_i = 1'b1;
    start_i = 1'b1;
    op_i    = EXE_DIVU_OP;
    #1 check_eq("flush_in_done", 64'({done_o, stall_o}), 64'(2'b10));
    @(negedge clk);
    flush_i = 1'b0;
    start_i = 1'b0;
    #1;
    check_eq("after_flush_done", 64'({busy_o, done_o}), 64'(0));
    check_eq("after_flush_hilo", {hi_o, lo_o}, last_hilo);

    // Reset in cycle 5 of a DIV drops everything at once
    start_i = 1'b1; op_i = EXE_DIV_OP; a_i = 32'hDEAD_BEEF; b_i = 32'd3;
    @(negedge clk);
    start_i = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("midop_rst_ctl", 64'({stall_o, busy_o, done_o}), 64'(0));
    check_eq("midop_rst_hilo", {hi_o, lo_o}, 64'(0));
    @(negedge clk);
    rst = 1'b0;
    last_hilo = '0;

    // Unsupported op is ignored
    start_i = 1'b1; op_i = EXE_AND_OP; a_i = 32'h5; b_i = 32'h6;
    #1 check_eq("bad_op_stall", 64'(stall_o), 64'(0));
    seen_done = 0;
    repeat (4) begin
      @(negedge clk);
      #1;
      if (busy_o !== 1'b0 || done_o !== 1'b0) seen_done++;
    end
    start_i = 1'b0;
    check_eq("bad_op_no_busy", 64'(seen_done), 64'(0));
    check_eq("bad_op_hilo", {hi_o, lo_o}, last_hilo);

    // Randomized operations
    @(negedge clk);
    #1;
    for (int i = 0; i < 40; i++) begin
      logic [7:0] op;
      op = ops[$urandom_range(0, 3)];
      run_op(op, pick_operand(), pick_operand(), is_mul_op(op) ? MulLat : div_lat,
             1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) != 0) step_idle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
